// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and default width for the bit-serial subtractor
package serial_sub_pkg;
  localparam int BIT_DEFAULT = 15;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/serial_subtractor_cell.sv
// subtractor: combinational 1-bit full subtractor cell
module subtractor (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);
  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial a - b with borrow, valid/ready on both sides
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int Bit = BIT_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Bit-1:0] a,
  input  logic [Bit-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [Bit-1:0] diff,
  output logic           borrow,
  output logic           busy
);
  localparam int CW = $clog2(Bit);
  localparam logic [CW-1:0] LAST = CW'(Bit - 1);
  state_e         state_q, state_d;
  logic [Bit-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           bor_q, bor_d, dbit, bout;
  subtractor u_cell (
    .a         (a_q[0]),
    .b         (b_q[0]),
    .borrow_in (bor_q),
    .diff      (dbit),
    .borrow_out(bout)
  );
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    bor_d   = bor_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        bor_d   = 1'b0;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        diff_d  = {dbit, diff_q[Bit-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        bor_d   = bout;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? DONE : RUN;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      bor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      bor_q   <= bor_d;
    end
  end
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = diff_q;
  assign borrow    = bor_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized scoreboard bench for 15-bit and 4-bit serial subtractors
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv15 = 1'b0, or15 = 1'b1, ir15, ov15, bor15, busy15;
  logic [14:0] a15 = '0, b15 = '0, d15;
  logic        iv4 = 1'b0, or4 = 1'b1, ir4, ov4, bor4, busy4;
  logic [3:0]  a4 = '0, b4 = '0, d4;
  bit          rand4_en = 1'b0;

  serial_subtractor #(.Bit(15)) dut15 (
    .clk(clk), .rst(rst), .in_valid(iv15), .in_ready(ir15), .a(a15), .b(b15),
    .out_valid(ov15), .out_ready(or15), .diff(d15), .borrow(bor15), .busy(busy15)
  );
  serial_subtractor #(.Bit(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .diff(d4), .borrow(bor4), .busy(busy4)
  );

  int checks = 0, errors = 0;
  logic [15:0] q15[$];
  logic [4:0]  q4[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: {borrow, diff} for w-bit unsigned operands
  function automatic int model(input int w, input int x, input int y);
    int m = 1 << w;
    return ((x < y) ? m : 0) | ((x - y + m) % m);
  endfunction

  always @(negedge clk) begin
    if (!rst && ov15 && or15) begin
      if (q15.size() == 0) begin
        checks++; errors++;
        $display("FAIL res15: unexpected result %0h, none expected", {bor15, d15});
      end else chk("res15", 32'({bor15, d15}), 32'(q15.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && ov4 && or4) begin
      if (q4.size() == 0) begin
        checks++; errors++;
        $display("FAIL res4: unexpected result %0h, none expected", {bor4, d4});
      end else chk("res4", 32'({bor4, d4}), 32'(q4.pop_front()));
    end
  end

  initial forever begin
    @(posedge clk);
    #1 if (rand4_en) or4 = ($urandom_range(0, 3) != 0);
  end

  task automatic wait_sig(input string name, input int which);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ((which == 0 && ir15) || (which == 1 && ov15) || (which == 2 && ir4)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: timeout, got 0 expected 1", name);
    end
  endtask

  task automatic send15(input logic [14:0] x, input logic [14:0] y);
    wait_sig("wait_ready15", 0);
    iv15 = 1'b1; a15 = x; b15 = y;
    q15.push_back(16'(model(15, int'(x), int'(y))));
    @(posedge clk);
    #1 iv15 = 1'b0; a15 = 15'($urandom); b15 = 15'($urandom);
  endtask

  task automatic send4(input logic [3:0] x, input logic [3:0] y);
    wait_sig("wait_ready4", 2);
    iv4 = 1'b1; a4 = x; b4 = y;
    q4.push_back(5'(model(4, int'(x), int'(y))));
    @(posedge clk);
    #1 iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
  endtask

  task automatic drain;
    for (int i = 0; i < 5000 && (q15.size() != 0 || q4.size() != 0); i++) @(posedge clk);
    chk("drain15", 32'(q15.size()), 0);
    chk("drain4", 32'(q4.size()), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ir15), 1);
    chk("rst_out_valid", 32'(ov15), 0);
    chk("rst_busy", 32'(busy15), 0);
    chk("rst_diff", 32'(d15), 0);
    chk("rst_borrow", 32'(bor15), 0);
    @(negedge clk) rst = 1'b0;
    // Latency: result visible exactly 15 edges after the accept edge
    send15(15'd5, 15'd3);
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1 chk("latency", 32'(ov15), 32'(i == 15));
    end
    send15(15'd3, 15'd5);
    send15(15'd0, 15'd1);
    send15(15'h7FFF, 15'h7FFF);
    send15(15'd0, 15'd0);
    for (int i = 0; i < 20; i++) send15(15'($urandom), 15'($urandom));
    wait_sig("idle15", 0);
    // Back-pressure with ignored in_valid pulses in RUN and DONE
    or15 = 1'b0;
    send15(15'h1234, 15'h0235);
    @(negedge clk) begin iv15 = 1'b1; a15 = 15'd7; b15 = 15'd9; end
    @(posedge clk);
    #1 chk("run_in_ready", 32'(ir15), 0);
    iv15 = 1'b0;
    wait_sig("wait_done15", 1);
    for (int i = 0; i < 10; i++) begin
      iv15 = 1'b1; a15 = 15'($urandom); b15 = 15'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(ov15), 1);
      chk("hold_in_ready", 32'(ir15), 0);
      chk("hold_result", 32'({bor15, d15}), 32'(model(15, 'h1234, 'h0235)));
    end
    // Consume result with next operands already offered: accepted one edge later
    a15 = 15'd1000; b15 = 15'd2000; iv15 = 1'b1; or15 = 1'b1;
    q15.push_back(16'(model(15, 1000, 2000)));
    @(posedge clk);
    #1 chk("b2b_in_ready", 32'(ir15), 1);
    chk("b2b_busy", 32'(busy15), 0);
    @(posedge clk);
    #1 chk("b2b_accepted", 32'(busy15), 1);
    iv15 = 1'b0;
    wait_sig("idle15b", 0);
    // Reset during the 7th RUN cycle discards the operation
    send15(15'h0100, 15'h0007);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(ir15), 1);
    chk("mid_rst_out_valid", 32'(ov15), 0);
    chk("mid_rst_busy", 32'(busy15), 0);
    chk("mid_rst_diff", 32'(d15), 0);
    chk("mid_rst_borrow", 32'(bor15), 0);
    void'(q15.pop_back());
    @(negedge clk) rst = 1'b0;
    send15(15'd100, 15'd40);
    drain();
    // Exhaustive 4-bit with random out_ready stalls
    rand4_en = 1'b1;
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) send4(4'(x), 4'(y));
    drain();
    rand4_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, multi-cycle subtractor computing `a - b` modulo 2^Bit plus a borrow flag, one bit per clock, LSB first. It is the counterpart of the parameterized ripple-carry adder. It trades Bit cycles of latency for a single 1-bit subtractor cell and a borrow flop. It sits in the datapath wherever the combinational Bit-wide subtract path is too large or too slow. It uses a valid/ready handshake on both sides.

## Interface
- `Bit`, 15, operand/result width in bits; legal range ≥ 2
- `clk`  in  1  single clock; all flops on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operands `a`, `b` present
- `in_ready`  out  1  block can accept operands (high only in IDLE)
- `a`  in  Bit  minuend
- `b`  in  Bit  subtrahend
- `out_valid`  out  1  `diff`/`borrow` valid
- `out_ready`  in  1  consumer accepts result
- `diff`  out  Bit  `(a - b) mod 2^Bit`
- `borrow`  out  1  1 iff `a < b` (unsigned)
- `busy`  out  1  high in RUN and DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready` = 1.
  - At an edge with `in_valid`: latch `a` and `b` into shift registers, clear the borrow flop, clear the bit counter, go to RUN.
- **RUN**
  - Each edge, the subtractor cell computes one bit from `a_sh[0]`, `b_sh[0]` and the borrow flop.
    - Difference bit = `a ^ b ^ bin`.
    - Borrow out = `(~a & b) | (~(a ^ b) & bin)`.
  - On the same edge:
    - The difference bit shifts into the `diff` register from the MSB end.
    - `a_sh` and `b_sh` shift right.
    - The borrow flop takes the cell's borrow out.
    - The counter increments.
  - After the edge that processes bit Bit-1 (counter reaches Bit-1 at that edge), go to DONE.
  - `borrow` output takes the final borrow.
- **DONE**
  - `out_valid` = 1; `diff` and `borrow` are stable.
  - At an edge with `out_ready`, go to IDLE and drop `out_valid`.
- **Ignored inputs**
  - `in_valid` is ignored in RUN and DONE; operands are not captured.
  - `a` and `b` may change freely after the accept edge.
- **Width rules**
  - Counter width is `$clog2(Bit)`.
  - `diff` wraps modulo 2^Bit; no signed interpretation.
- **Reset mid-operation:** async return to IDLE. The in-flight operation is discarded and no result is emitted.

## Timing
- **Reset values:**
  - `in_ready` = 1
  - `out_valid` = 0
  - `busy` = 0
  - `diff` = 0
  - `borrow` = 0
  - internal shift registers, counter and borrow flop = 0
- **Latency:** operands accepted at edge k; bits 0..Bit-1 processed at edges k+1..k+Bit; `out_valid` rises after edge k+Bit.
- **Throughput:** minimum Bit+2 cycles per operation (accept, Bit run cycles, 1 DONE cycle with `out_ready` already high).
- **Back-to-back:** `in_ready` is high no earlier than the cycle after the result handshake.
  - `out_ready` and `in_valid` high together in DONE: only the result is consumed.
  - Next operands are accepted at the following edge if `in_valid` is still high.
- **Back-pressure:** `out_valid`, `diff` and `borrow` hold indefinitely while `out_ready` = 0.
- **Combinational decode:** `in_ready` and `busy` decode from state only, with no input-to-output combinational path.

## Structure
- **Shared package `serial_sub_pkg`:**
  - state enum `{IDLE, RUN, DONE}`, 2-bit encoding
  - `Bit` default constant
- **Sub-module `subtractor`:** combinational 1-bit full subtractor with ports `a`, `b`, `borrow_in`, `diff`, `borrow_out`. It mirrors the existing 1-bit adder cell and is instantiated once.
- **Top level:** FSM, counter, shift registers, borrow flop.

## Test plan
- Bit=15, a=5, b=3 -> `diff`=0x0002, `borrow`=0; `out_valid` rises exactly 15 edges after the accept edge.
- Bit=15, a=3, b=5 -> `diff`=0x7FFE, `borrow`=1; also a=0, b=1 -> `diff`=0x7FFF, `borrow`=1.
- Bit=15, a=b=0x7FFF -> `diff`=0, `borrow`=0; a=b=0 -> `diff`=0, `borrow`=0.
- Back-pressure: hold `out_ready`=0 for 10 cycles after `out_valid` -> result held stable; `in_valid` pulses with new operands during RUN and DONE are not captured; next accepted result matches operands presented in IDLE.
- Reset asserted at the 7th RUN cycle -> outputs return to reset values immediately; after release, a=100, b=40 -> `diff`=60, `borrow`=0.
- Bit=4 exhaustive: all 256 (a, b) pairs with random `out_ready` stalls -> `diff` == (a-b)&0xF and `borrow` == (a<b) for each.
